// File: rtl/voice_mixer_pkg.sv
// Shared types and helpers for the voice mixer: FSM state enum,
// accumulator width computation and the output range check.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } mix_state_t;

  // Widest scaled value the range check accepts; callers sign-extend into it.
  localparam int SAT_MAX_W = 128;

  // clip: value lies outside the signed out_w range; neg: it is negative,
  // so a clipped value pins to the most negative code.
  typedef struct packed {
    logic clip;
    logic neg;
  } sat_t;

  // Product bits, plus growth for summing nv voices, plus one guard bit.
  function automatic int acc_width(input int nv, input int sw, input int vw);
    return sw + vw + 1 + $clog2(nv) + 1;
  endfunction

  // Range check of a signed value against [-2^(out_w-1), 2^(out_w-1)-1].
  function automatic sat_t saturate(input logic signed [SAT_MAX_W-1:0] v,
                                    input int out_w);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sat_t r;
    hi = SAT_MAX_W'(1) <<< (out_w - 1);
    lo = -hi;
    hi = hi - SAT_MAX_W'(1);
    r.clip = (v > hi) || (v < lo);
    r.neg  = v[SAT_MAX_W-1];
    return r;
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Frame request / result bus between the mixer and its neighbours.
interface voice_mixer_if #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24,
  parameter int VOL_W      = 7
);
  logic                           sample_strobe;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
  logic [NUM_VOICES*VOL_W-1:0]    voice_gain;
  logic [NUM_VOICES-1:0]          voice_enable;
  logic [VOL_W-1:0]               master_vol;
  logic                           clear_flags;
  logic [SAMPLE_W-1:0]            mixed_sample;
  logic                           mixed_valid;
  logic                           busy;
  logic                           clip;
  logic                           overrun;

  modport master (
    output sample_strobe, voice_sample, voice_gain, voice_enable, master_vol, clear_flags,
    input  mixed_sample, mixed_valid, busy, clip, overrun
  );

  modport slave (
    input  sample_strobe, voice_sample, voice_gain, voice_enable, master_vol, clear_flags,
    output mixed_sample, mixed_valid, busy, clip, overrun
  );
endinterface

// File: rtl/voice_mixer_mac.sv
// Registered signed sample x unsigned gain multiply-accumulate, shared by
// all voices of a frame. clr has priority over en.
module voice_mac #(
  parameter int SAMPLE_W = 24,
  parameter int VOL_W    = 7,
  parameter int ACC_W    = 35
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic        [VOL_W-1:0]    gain_i,
  output logic signed [ACC_W-1:0]    acc_o
);
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d, acc_q;

  // Gain is zero-extended so it multiplies as a non-negative signed value.
  always_comb begin
    prod  = $signed({{(VOL_W+1){sample_i[SAMPLE_W-1]}}, sample_i}) *
            $signed({{(SAMPLE_W+1){1'b0}}, gain_i});
    acc_d = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: snapshots all voices on the frame strobe,
// accumulates one voice per cycle, applies master volume with headroom
// shift, saturates and presents one sample per frame.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24,
  parameter int VOL_W      = 7,
  parameter int HEADROOM   = 2
) (
  input  logic          clk,
  input  logic          reset,
  voice_mixer_if.slave  bus
);
  localparam int ACC_W = acc_width(NUM_VOICES, SAMPLE_W, VOL_W);
  localparam int SCL_W = ACC_W + VOL_W + 1;
  localparam int SHIFT = 2*VOL_W + HEADROOM;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  mix_state_t state_q, state_d;
  logic                                 load, mac_en;
  logic [IDX_W-1:0]                     idx_q;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  smp_q;
  logic [NUM_VOICES-1:0][VOL_W-1:0]     gain_q;
  logic [NUM_VOICES-1:0]                en_q;
  logic [VOL_W-1:0]                     mvol_q;
  logic signed [ACC_W-1:0]              acc;
  logic signed [SCL_W-1:0]              scl_prod, scaled;
  logic signed [SAT_MAX_W-1:0]          wide;
  sat_t                                 sat;
  logic [SAMPLE_W-1:0]                  mixed_d, mixed_q;
  logic                                 valid_q, clip_q, ovr_q;
  logic                                 clip_set, ovr_set;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; load marks strobe acceptance, mac_en gates disabled voices.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.sample_strobe) begin
        state_d = ACCUM;
        load    = 1'b1;
      end
      ACCUM: begin
        mac_en = en_q[idx_q];
        if (idx_q == IDX_W'(NUM_VOICES-1)) state_d = SCALE;
      end
      SCALE:   state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot of all frame inputs; later input changes do not reach the mix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_q  <= '0;
      gain_q <= '0;
      en_q   <= '0;
      mvol_q <= '0;
    end else if (load) begin
      smp_q  <= bus.voice_sample;
      gain_q <= bus.voice_gain;
      en_q   <= bus.voice_enable;
      mvol_q <= bus.master_vol;
    end
  end

  // Voice index walks 0..NUM_VOICES-1 during ACCUM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 idx_q <= '0;
    else if (load)             idx_q <= '0;
    else if (state_q == ACCUM) idx_q <= idx_q + 1'b1;
  end

  voice_mac #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (load),
    .en_i     (mac_en),
    .sample_i ($signed(smp_q[idx_q])),
    .gain_i   (gain_q[idx_q]),
    .acc_o    (acc)
  );

  // Master scaling; >>> floors toward -inf, then clamp to the sample range.
  always_comb begin
    scl_prod = $signed({{(VOL_W+1){acc[ACC_W-1]}}, acc}) *
               $signed({{(ACC_W+1){1'b0}}, mvol_q});
    scaled   = scl_prod >>> SHIFT;
    wide     = $signed({{(SAT_MAX_W-SCL_W){scaled[SCL_W-1]}}, scaled});
    sat      = saturate(wide, SAMPLE_W);
    mixed_d  = !sat.clip ? scaled[SAMPLE_W-1:0] : (sat.neg ? S_MIN : S_MAX);
    clip_set = (state_q == SCALE) && sat.clip;
    ovr_set  = bus.sample_strobe && (state_q != IDLE);
  end

  // Result loads at the end of SCALE so it and the valid pulse appear
  // together in the OUTPUT cycle; flag sets win over clear_flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mixed_q <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= (state_q == SCALE);
      if (state_q == SCALE) mixed_q <= mixed_d;
      clip_q  <= clip_set | (clip_q & ~bus.clear_flags);
      ovr_q   <= ovr_set  | (ovr_q  & ~bus.clear_flags);
    end
  end

  assign bus.mixed_sample = mixed_q;
  assign bus.mixed_valid  = valid_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.clip         = clip_q;
  assign bus.overrun      = ovr_q;
endmodule
